// File: rtl/key_loader_pkg.sv
// Shared types and width helper for the serial key loader.
package key_loader_pkg;

   typedef enum logic [2:0] {
      KL_IDLE   = 3'd0,
      KL_SHIFT  = 3'd1,
      KL_CHECK  = 3'd2,
      KL_LOCKED = 3'd3,
      KL_ERROR  = 3'd4
   } kl_state_t;

   // Trailer width able to hold a popcount of 0..key_w.
   function automatic int unsigned kl_chk_w(input int unsigned key_w);
      return $clog2(key_w + 1);
   endfunction

endpackage

// File: rtl/key_ones_counter.sv
// Popcount accumulator for the key phase; clear wins over enable.
module key_ones_counter #(
   parameter int unsigned W = 6
) (
   input  logic         cp,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + W'(inc_i);
   end

   always_ff @(posedge cp) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/key_scan_loader.sv
// Serial key loader: shifts in key + popcount trailer, checks it, then
// drives the accepted key in parallel to the locked netlist.
module key_scan_loader
   import key_loader_pkg::*;
#(
   parameter int unsigned KEY_W = 32,
   parameter int unsigned CHK_W = kl_chk_w(KEY_W)
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             start,
   input  logic             se,
   input  logic             si,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             busy,
   output logic             err
);

   localparam int unsigned TOT_W = KEY_W + CHK_W;
   localparam int unsigned CNT_W = $clog2(TOT_W + 1);

   kl_state_t          state_q;
   logic [TOT_W-1:0]   sr_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [KEY_W-1:0]   key_q;
   logic               key_valid_q;
   logic               busy_q;
   logic               err_q;

   logic [CHK_W-1:0]   ones_c;
   logic               restart_c;
   logic               key_phase_c;
   logic               ones_clr_c;
   logic               ones_en_c;

   // start is honoured everywhere except the single CHECK cycle
   assign restart_c   = start && (state_q != KL_CHECK);
   assign key_phase_c = bit_cnt_q < CNT_W'(KEY_W);
   assign ones_clr_c  = rst || restart_c;
   assign ones_en_c   = (state_q == KL_SHIFT) && se && !start && key_phase_c;

   key_ones_counter #(
      .W (CHK_W)
   ) u_ones (
      .cp    (cp),
      .clr_i (ones_clr_c),
      .en_i  (ones_en_c),
      .inc_i (si),
      .cnt_o (ones_c)
   );

   always_ff @(posedge cp) begin
      if (rst) begin
         state_q     <= KL_IDLE;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            KL_IDLE, KL_LOCKED, KL_ERROR: begin
               if (start) begin
                  state_q     <= KL_SHIFT;
                  sr_q        <= '0;
                  bit_cnt_q   <= '0;
                  key_q       <= '0;
                  key_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            KL_SHIFT: begin
               if (start) begin
                  sr_q      <= '0;
                  bit_cnt_q <= '0;
               end else if (se) begin
                  sr_q      <= {sr_q[TOT_W-2:0], si};
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(TOT_W - 1))
                     state_q <= KL_CHECK;
               end
            end
            KL_CHECK: begin
               busy_q <= 1'b0;
               if (sr_q[CHK_W-1:0] == ones_c) begin
                  state_q     <= KL_LOCKED;
                  key_q       <= sr_q[TOT_W-1:CHK_W];
                  key_valid_q <= 1'b1;
               end else begin
                  state_q <= KL_ERROR;
                  err_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= KL_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_key_scan_loader.sv
// Self-checking bench for key_scan_loader at default widths (KEY_W=32, CHK_W=6).
module tb_key_scan_loader;

   localparam int unsigned KEY_W = 32;
   localparam int unsigned CHK_W = 6;
   localparam int unsigned TOT_W = KEY_W + CHK_W;

   logic             cp = 1'b0;
   logic             rst;
   logic             start;
   logic             se;
   logic             si;
   logic [KEY_W-1:0] key;
   logic             key_valid;
   logic             busy;
   logic             err;

   int checks = 0;
   int errors = 0;

   always #5 cp = ~cp;

   key_scan_loader #(
      .KEY_W (KEY_W),
      .CHK_W (CHK_W)
   ) dut (
      .cp        (cp),
      .rst       (rst),
      .start     (start),
      .se        (se),
      .si        (si),
      .key       (key),
      .key_valid (key_valid),
      .busy      (busy),
      .err       (err)
   );

   typedef struct {
      logic [KEY_W-1:0] k;
      logic [CHK_W-1:0] t;
      int               gap_every;
      int               gap_len;
      logic             exp_ok;
   } vec_t;

   // Reference: a load is accepted iff the trailer equals the key popcount.
   function automatic logic ref_ok(input logic [KEY_W-1:0] k, input logic [CHK_W-1:0] t);
      return ($countones(k) == int'(t));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] k, input logic kv,
                          input logic b, input logic e);
      chk({tag, " key"}, key, k);
      chk({tag, " key_valid"}, {31'd0, key_valid}, {31'd0, kv});
      chk({tag, " busy"}, {31'd0, busy}, {31'd0, b});
      chk({tag, " err"}, {31'd0, err}, {31'd0, e});
   endtask

   task automatic step();
      @(posedge cp);
      #1;
   endtask

   // Full load: start pulse, TOT_W bits with optional se gaps, then the CHECK cycle.
   task automatic load(input string tag, input logic [KEY_W-1:0] k, input logic [CHK_W-1:0] t,
                       input int gap_every, input int gap_len, input logic exp_ok);
      logic [TOT_W-1:0] stream;
      stream = {k, t};
      start = 1'b1; se = 1'($urandom); si = 1'($urandom);
      step();
      start = 1'b0;
      chk_out({tag, " start"}, 32'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < int'(TOT_W); i++) begin
         se = 1'b1; si = stream[TOT_W-1-i];
         step();
         chk_out({tag, " shift"}, 32'd0, 1'b0, 1'b1, 1'b0);
         if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i != int'(TOT_W) - 1) begin
            for (int g = 0; g < gap_len; g++) begin
               se = 1'b0; si = 1'($urandom);
               step();
               chk_out({tag, " gap"}, 32'd0, 1'b0, 1'b1, 1'b0);
            end
         end
      end
      se = 1'($urandom); si = 1'($urandom);
      step();
      chk_out({tag, " done"}, exp_ok ? k : 32'd0, exp_ok, 1'b0, ~exp_ok);
   endtask

   task automatic hold(input string tag, input int n, input logic [KEY_W-1:0] k,
                       input logic kv, input logic e);
      for (int c = 0; c < n; c++) begin
         start = 1'b0; se = 1'($urandom); si = 1'($urandom);
         step();
         chk_out(tag, k, kv, 1'b0, e);
      end
   endtask

   task automatic partial(input int nbits);
      start = 1'b1; se = 1'b1; si = 1'($urandom);
      step();
      start = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         se = 1'b1; si = 1'($urandom);
         step();
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'hA5A5_00FF, 6'b010000, 0, 0, 1'b1};
      vecs[1] = '{32'hA5A5_00FF, 6'b010001, 0, 0, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 6'b100000, 0, 0, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 6'b011111, 4, 1, 1'b0};
      vecs[4] = '{32'h0000_0000, 6'b000000, 7, 2, 1'b1};
      vecs[5] = '{32'h8000_0001, 6'b000010, 1, 1, 1'b1};

      // Reset with random inputs
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         start = 1'($urandom); se = 1'($urandom); si = 1'($urandom);
         step();
         chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0; start = 1'b0; se = 1'b0; si = 1'b0;
      step();
      chk_out("idle", 32'd0, 1'b0, 1'b0, 1'b0);

      // Good load held for 100 cycles
      load("good", 32'hA5A5_00FF, 6'b010000, 0, 0, 1'b1);
      hold("good hold", 100, 32'hA5A5_00FF, 1'b1, 1'b0);

      // Bad trailer, then start clears err
      load("bad", 32'hA5A5_00FF, 6'b010001, 0, 0, 1'b0);
      hold("bad hold", 5, 32'd0, 1'b0, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("bad restart", 32'd0, 1'b0, 1'b1, 1'b0);

      // se gaps (3 idle cycles after every 5th bit)
      load("gaps", 32'hA5A5_00FF, 6'b010000, 5, 3, 1'b1);
      hold("gaps hold", 3, 32'hA5A5_00FF, 1'b1, 1'b0);

      // Restart after 10 bits of a partial load
      partial(10);
      chk_out("partial", 32'd0, 1'b0, 1'b1, 1'b0);
      load("restart", 32'h0000_0001, 6'b000001, 0, 0, 1'b1);

      // start in LOCKED drops the key at the next edge
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("relock", 32'd0, 1'b0, 1'b1, 1'b0);

      // Reset mid-shift after 20 bits
      partial(20);
      rst = 1'b1;
      step();
      chk_out("mid rst", 32'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("post rst", 32'd0, 1'b0, 1'b0, 1'b0);
      load("after rst", 32'h1234_5678, 6'd13, 0, 0, 1'b1);

      // Table vectors
      foreach (vecs[i]) begin
         load($sformatf("vec%0d", i), vecs[i].k, vecs[i].t, vecs[i].gap_every,
              vecs[i].gap_len, vecs[i].exp_ok);
         hold($sformatf("vec%0d hold", i), 2, vecs[i].exp_ok ? vecs[i].k : 32'd0,
              vecs[i].exp_ok, ~vecs[i].exp_ok);
      end

      // Randomised loads against the popcount model
      for (int r = 0; r < 20; r++) begin
         logic [KEY_W-1:0] k;
         logic [CHK_W-1:0] t;
         logic             ok;
         k = $urandom;
         if ($urandom_range(0, 1) == 1)
            t = CHK_W'($countones(k));
         else
            t = CHK_W'($urandom);
         ok = ref_ok(k, t);
         load($sformatf("rnd%0d", r), k, t, $urandom_range(0, 7), $urandom_range(1, 3), ok);
         hold($sformatf("rnd%0d hold", r), 3, ok ? k : 32'd0, ok, ~ok);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_scan_loader.md
# key_scan_loader

Serial key loader that sits directly upstream of the locked netlist built from our camouflaged cell variants (`_1`/`_2`/`_3`). It shifts in a key plus a popcount trailer over a one-bit port and checks the trailer. It then presents the key in parallel to the select/key inputs of the obfuscated gates. Until a key has been accepted, the key bus is forced to zero, so the locked logic runs in its default (wrong) configuration.

## Interface
Parameters:
- `KEY_W`, default 32: key width in bits; must be ≥ 2.
- `CHK_W`, default `$clog2(KEY_W+1)`: trailer width; holds the key popcount.

Ports:
- `cp`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: begin or restart a load; sampled every cycle.
- `se`, input, 1: shift enable; `si` is sampled only when `se`=1 in SHIFT.
- `si`, input, 1: serial data, MSB first. Order is key bits `KEY_W-1..0`, then trailer bits `CHK_W-1..0`.
- `key`, output, `KEY_W`: accepted key; all zeros unless `key_valid`=1.
- `key_valid`, output, 1: key accepted and driving `key`.
- `busy`, output, 1: high in SHIFT and CHECK.
- `err`, output, 1: last load failed the trailer check.

## Operation
- States:
  - IDLE: post-reset.
  - SHIFT: collecting bits.
  - CHECK: one cycle.
  - LOCKED: key accepted.
  - ERROR: load rejected.
- IDLE/LOCKED/ERROR + `start` → SHIFT.
  - Clear the bit counter, shift register and ones counter.
  - Drop `key_valid` and `err`; `key` goes to 0.
  - The `si` value in the `start` cycle is not sampled.
- SHIFT:
  - On each `se`=1 cycle, shift `si` into the LSB of the shift register and increment the bit counter.
  - During the key phase (counter < `KEY_W`), add `si` to the ones counter.
  - The ones counter is `CHK_W` wide and never saturates, since popcount ≤ `KEY_W` < 2^`CHK_W`.
  - `se`=0 holds all state.
  - The transition to CHECK happens on the edge that samples bit number `KEY_W+CHK_W-1`, counting from 0.
- SHIFT + `start`: restart. Clear everything, stay in SHIFT; this takes priority over `se`.
- CHECK: compare the trailer (low `CHK_W` bits of the shift register) with the ones counter.
  - Equal → LOCKED. Load the key register from the upper `KEY_W` bits and set `key_valid`.
  - Not equal → ERROR. Set `err`; the key register stays zero.
  - `start` in CHECK is ignored.
- LOCKED holds `key` indefinitely; `se`/`si` are ignored.
- ERROR holds `err`=1 until `start` or `rst`.
- `rst` from any state, including mid-shift:
  - Next state is IDLE.
  - `key`=0, `key_valid`=0, `busy`=0, `err`=0.
  - Counters and shift register are cleared.
- `key` is registered, not gated combinationally, so the locked netlist sees glitch-free inputs.

## Timing
- Reset values: all outputs 0, state IDLE.
- `busy` rises the cycle after the `start` edge. It falls in the same cycle that `key_valid` or `err` rises.
- Latency: if the last trailer bit is sampled at edge N, then CHECK is active in cycle N→N+1. `key_valid`/`err` are registered at edge N+1, visible from N+1.
- Minimum load time: 1 (`start`) + `KEY_W+CHK_W` + 1 (CHECK) cycles. This is 40 cycles at the defaults.
- There is no back-pressure; `se` gaps only stretch the SHIFT phase.
- `start` in LOCKED drops `key_valid` and `key` at the next edge, so the old key is not retained.

## Structure
- Package `key_loader_pkg`:
  - state enum `kl_state_t` (IDLE, SHIFT, CHECK, LOCKED, ERROR);
  - function `kl_chk_w(key_w)` returning `$clog2(key_w+1)`.
- Sub-module `key_ones_counter`: `CHK_W`-bit counter with clear, enable and increment inputs, synchronous to `cp`.
  - It is instantiated once.
  - It is kept separate so synthesis maps it onto `DFQD1`/`XOR2D1`/`AN2D1` cells independently.
- Top level: FSM, `KEY_W+CHK_W` shift register, bit counter of width `$clog2(KEY_W+CHK_W+1)`, and the key register.

## Test plan
All cases use the defaults (`KEY_W`=32, `CHK_W`=6).
- Reset: hold `rst` 2 cycles with random `start`/`se`/`si` → `key`=0, `key_valid`=0, `busy`=0, `err`=0, in every cycle after the first edge.
- Good load: `start`, then 38 bits with `se`=1. Bits are key 0xA5A5_00FF MSB first, then trailer 6'b010000 (popcount 16). Required response:
  - `busy`=1 for 39 cycles;
  - then `key_valid`=1 and `key`=0xA5A5_00FF, held for 100 cycles;
  - `err`=0 throughout.
- Bad trailer: same key with trailer 6'b010001 → `err`=1, `key_valid`=0, `key`=0. A following `start` clears `err` the next cycle.
- `se` gaps: good load with `se` low for 3 cycles after every 5th bit → identical `key`, with `key_valid` delayed by the gap count.
- Restart: `start` after 10 bits of a partial load, then a full good load of 0x0000_0001 with trailer 6'b000001 → `key`=0x0000_0001, `key_valid`=1.
- Reset mid-shift and reload from LOCKED:
  - `rst` after 20 bits → IDLE with all outputs 0; a subsequent good load succeeds.
  - `start` in LOCKED → `key_valid`=0 and `key`=0 at the next edge.
